collision_hitstop: RTL and testbench
====================================

// Module: collision_hitstop
// PURPOSE
//  Other end of the obstacle drawer's check_hit input: watches per-pixel goose/bean flags on the VGA scan and detects overlap.
//  Commits a hit once per frame and decrements lives. Holds check_hit for a hit-stop window of N frames, then releases.
//  Sits between the draw_* pixel generators and the obstacle/score logic in the top level.
// PARAMETERS
//  H_TOTAL          800  pixels per line incl. blanking (x counts 0..H_TOTAL-1)
//  V_TOTAL          525  lines per frame (y counts 0..V_TOTAL-1)
//  HITSTOP_FRAMES   30   frames check_hit stays high after a non-fatal hit (>=1)
//  LIVES            3    lives at reset (1..7)
//  MIN_OVERLAP      4    overlapping pixels in one frame needed to count as a hit (1..255)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high; clock clk
//  pixel_tick   in   1   pixel enable; x/y/flags valid when high
//  x            in   10  current scan column
//  y            in   10  current scan row
//  video_on     in   1   visible-area flag
//  goose        in   1   goose pixel flag
//  bean         in   1   obstacle pixel flag (from draw_bean)
//  check_hit    out  1   freeze request to obstacle logic; high in STOP and OVER
//  hit_pulse    out  1   one-clk strobe on each committed hit
//  game_over    out  1   high in OVER
//  lives_left   out  3   remaining lives
//  flash        out  1   goose blink enable (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state RUN, lives_left=LIVES, overlap count 0, stop count 0; all other outputs 0. Reset beats any same-cycle tick.
//  - frame_tick = pixel_tick & x==H_TOTAL-1 & y==V_TOTAL-1 (one clk).
//  - ovl = pixel_tick & video_on & goose & bean.
//  - ovl_cnt: 8-bit, saturates at 255. Increments on ovl in RUN only; held 0 in STOP/OVER.
//    Cleared on every frame_tick, after evaluation.
//  - Evaluation at frame_tick uses ovl_cnt + ovl (the current pixel counts).
//  - FSM:
//    RUN -> on frame_tick with eval>=MIN_OVERLAP: lives_left-=1, hit_pulse=1.
//           New lives==0 -> OVER; else -> STOP with stop_cnt=HITSTOP_FRAMES.
//    STOP -> stop_cnt-=1 on each frame_tick. On the frame_tick where stop_cnt==1 -> RUN.
//            Gives exactly HITSTOP_FRAMES frame ticks in STOP; overlaps ignored.
//    OVER -> sticky until reset.
//  - Outputs registered. check_hit/game_over/lives_left change the clk after the committing frame_tick; hit_pulse is that same clk.
//  - At most one hit per frame. Overlap spanning many frames re-hits on the first RUN frame after STOP ends.
//  - lives_left never underflows; it is 0 only in OVER.
// CONFIGURATION
//  HIT_FLASH_EN defined: in STOP, flash toggles every 4 frame_ticks, starting 1 on STOP entry; flash=0 outside STOP.
//  Not defined: flash tied 0; no frame-divider logic.
// STRUCTURE
//  Shared package collision_pkg: state typedef {RUN,STOP,OVER}; H_TOTAL/V_TOTAL defaults; counter widths.
//  Sub-module frame_tick_gen (x,y,pixel_tick -> frame_tick); reused by the score and obstacle blocks.
// TESTING
//  1. Reset, 3 frames with no overlap -> check_hit=0, lives_left=3, hit_pulse never high.
//  2. Frame with 4 ovl pixels, MIN_OVERLAP=4 -> hit_pulse at frame end; lives_left=2; check_hit high exactly 30 frames, then 0.
//  3. Frame with 3 ovl pixels -> no hit. Next frame ovl count restarts from 0 (no carry-over).
//  4. Continuous overlap every frame, LIVES=3 -> hits on frames 1, 32, 63; third hit -> OVER. game_over=1, check_hit stays 1 forever.
//  5. reset asserted mid-STOP (frame 10 of 30) -> next clk RUN, lives_left=3, check_hit=0.
//  6. 4th ovl pixel coincides with frame_tick pixel -> counts as hit. With HIT_FLASH_EN: flash pattern 1,1,1,1,0,0,0,0,... per frame in STOP.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and widths for the collision/hit-stop path and its frame-tick helper.
package collision_pkg;

  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned V_TOTAL_DEF = 525;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned LIVES_W     = 3;
  localparam int unsigned OVL_W       = 8;

  typedef logic [1:0] state_t;
  localparam state_t RUN  = 2'd0;
  localparam state_t STOP = 2'd1;
  localparam state_t OVER = 2'd2;

  function automatic logic [OVL_W-1:0] sat_inc(input logic [OVL_W-1:0] v);
    return (&v) ? v : v + OVL_W'(1);
  endfunction

endpackage

// File: rtl/collision_hitstop_if.sv
// Scan-side inputs and game-side outputs of collision_hitstop.
// master drives the pixel scan; slave is the collision block.
interface collision_hitstop_if;
  import collision_pkg::*;

  logic               pixel_tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               video_on;
  logic               goose;
  logic               bean;
  logic               check_hit;
  logic               hit_pulse;
  logic               game_over;
  logic [LIVES_W-1:0] lives_left;
  logic               flash;

  modport master (
    output pixel_tick, x, y, video_on, goose, bean,
    input  check_hit, hit_pulse, game_over, lives_left, flash
  );

  modport slave (
    input  pixel_tick, x, y, video_on, goose, bean,
    output check_hit, hit_pulse, game_over, lives_left, flash
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-clock strobe on the last pixel of the frame (bottom-right corner incl. blanking).
module frame_tick_gen
  import collision_pkg::*;
#(
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
    input  logic               pixel_tick_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               frame_tick_o
);

    localparam logic [COORD_W-1:0] XLast = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] YLast = COORD_W'(V_TOTAL - 1);

    assign frame_tick_o = pixel_tick_i & (x_i == XLast) & (y_i == YLast);

endmodule

// File: rtl/collision_hitstop.sv
// Goose/bean overlap detector: commits at most one hit per frame, then freezes the game
// for HITSTOP_FRAMES frames. Optional goose blink in the freeze window with HIT_FLASH_EN.
module collision_hitstop
  import collision_pkg::*;
#(
    parameter int unsigned H_TOTAL        = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL        = V_TOTAL_DEF,
    parameter int unsigned HITSTOP_FRAMES = 30,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned MIN_OVERLAP    = 4
) (
    input logic                clk,
    input logic                reset,
    collision_hitstop_if.slave bus
);

    localparam int unsigned        StopW     = $clog2(HITSTOP_FRAMES + 1);
    localparam logic [StopW-1:0]   StopInit  = StopW'(HITSTOP_FRAMES);
    localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES);
    localparam logic [OVL_W:0]     MinOvl    = (OVL_W + 1)'(MIN_OVERLAP);

    logic frame_tick;

    frame_tick_gen #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_frame_tick_gen (
        .pixel_tick_i(bus.pixel_tick),
        .x_i         (bus.x),
        .y_i         (bus.y),
        .frame_tick_o(frame_tick)
    );

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [StopW-1:0]   stop_cnt_q, stop_cnt_d;
    logic [OVL_W-1:0]   ovl_cnt_q, ovl_cnt_d;
    logic               hit_q, hit_d;
    logic               ovl;
    logic [OVL_W:0]     eval;

    assign ovl = bus.pixel_tick & bus.video_on & bus.goose & bus.bean;
    // The frame's last pixel still counts toward that frame's verdict.
    assign eval = {1'b0, ovl_cnt_q} + {{OVL_W{1'b0}}, ovl};

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        stop_cnt_d = stop_cnt_q;
        ovl_cnt_d  = ovl_cnt_q;
        hit_d      = 1'b0;
        case (state_q)
            RUN: begin
                if (frame_tick) begin
                    ovl_cnt_d = '0;
                    if (eval >= MinOvl) begin
                        hit_d   = 1'b1;
                        lives_d = lives_q - LIVES_W'(1);
                        if (lives_q == LIVES_W'(1)) begin
                            state_d = OVER;
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = StopInit;
                        end
                    end
                end else if (ovl) begin
                    ovl_cnt_d = sat_inc(ovl_cnt_q);
                end
            end
            STOP: begin
                ovl_cnt_d = '0;
                if (frame_tick) begin
                    stop_cnt_d = stop_cnt_q - StopW'(1);
                    if (stop_cnt_q == StopW'(1)) state_d = RUN;
                end
            end
            OVER: begin
                ovl_cnt_d = '0;
            end
            default: begin
                state_d   = RUN;
                ovl_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            lives_q    <= LivesInit;
            stop_cnt_q <= '0;
            ovl_cnt_q  <= '0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            stop_cnt_q <= stop_cnt_d;
            ovl_cnt_q  <= ovl_cnt_d;
            hit_q      <= hit_d;
        end
    end

    assign bus.check_hit  = (state_q != RUN);
    assign bus.game_over  = (state_q == OVER);
    assign bus.lives_left = lives_q;
    assign bus.hit_pulse  = hit_q;

`ifdef HIT_FLASH_EN
    logic       flash_q, flash_d;
    logic [1:0] fdiv_q, fdiv_d;

    // Blink period is 8 frames: 4 on, 4 off, starting on at STOP entry.
    always_comb begin
        flash_d = flash_q;
        fdiv_d  = fdiv_q;
        if (state_q == RUN && state_d == STOP) begin
            flash_d = 1'b1;
            fdiv_d  = 2'd0;
        end else if (state_q == STOP && state_d == RUN) begin
            flash_d = 1'b0;
        end else if (state_q == STOP && frame_tick) begin
            fdiv_d = fdiv_q + 2'd1;
            if (fdiv_q == 2'd3) flash_d = ~flash_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= 1'b0;
            fdiv_q  <= 2'd0;
        end else begin
            flash_q <= flash_d;
            fdiv_q  <= fdiv_d;
        end
    end

    assign bus.flash = flash_q;
`else
    assign bus.flash = 1'b0;
`endif

endmodule

// File: tb/tb_collision_hitstop.sv
// Randomized scan stimulus against a frame-level reference model; a monitor pops expected
// per-frame results from a queue and also checks outputs hold steady between frames.
module tb_collision_hitstop;
    import collision_pkg::*;

    localparam int H  = 10;
    localparam int V  = 4;
    localparam int FP = H * V;
    localparam int HS = 30;
    localparam int LV = 3;
    localparam int MO = 4;

    typedef struct {
        bit hit;
        int lives;
        bit chk;
        bit over;
        bit flash;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    collision_hitstop_if bus ();

    collision_hitstop #(
        .H_TOTAL       (H),
        .V_TOTAL       (V),
        .HITSTOP_FRAMES(HS),
        .LIVES         (LV),
        .MIN_OVERLAP   (MO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    int   sx = 0;
    int   sy = 0;
    exp_t exp_q[$];

    // Reference state: whole-frame view of the game.
    int m_lives = LV;
    int m_stop = 0;   // frames of freeze still to come
    int m_k = 0;      // frames elapsed since freeze began
    int m_cnt = 0;    // overlap pixels seen this frame
    bit m_over = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    function automatic void model_update();
        exp_t e;
        bit   ft;
        bit   run;
        if (reset) begin
            m_lives = LV; m_stop = 0; m_k = 0; m_cnt = 0; m_over = 0;
            e.hit = 0;
        end else begin
            ft  = bus.pixel_tick && sx == H - 1 && sy == V - 1;
            run = !m_over && m_stop == 0;
            if (run && bus.pixel_tick && bus.video_on && bus.goose && bus.bean && m_cnt < 255)
                m_cnt++;
            if (!ft) return;
            e.hit = 0;
            if (run) begin
                if (m_cnt >= MO) begin
                    e.hit = 1;
                    m_lives--;
                    if (m_lives == 0) m_over = 1;
                    else begin m_stop = HS; m_k = 0; end
                end
            end else if (m_stop > 0) begin
                m_stop--;
                m_k++;
            end
            m_cnt = 0;
        end
        e.lives = m_lives;
        e.chk   = m_over || m_stop > 0;
        e.over  = m_over;
`ifdef HIT_FLASH_EN
        e.flash = (m_stop > 0) && ((m_k / 4) % 2 == 0);
`else
        e.flash = 0;
`endif
        exp_q.push_back(e);
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // mode 1: last n pixels overlap; mode 2: first n pixels overlap; mode 3: fully random.
    task automatic drive_frame(input int mode, input int n, input int tick_pct);
        bit done;
        int idx;
        bit pt;
        bit ins;
        done = 0;
        while (!done) begin
            idx = sy * H + sx;
            pt  = int'($urandom_range(0, 99)) < tick_pct;
            ins = (mode == 1) ? (idx >= FP - n) : (mode == 2) ? (idx < n) : 1'b0;
            bus.pixel_tick = pt;
            bus.x = 10'(sx);
            bus.y = 10'(sy);
            if (mode == 3) begin
                bus.video_on = 1'($urandom());
                bus.goose    = 1'($urandom());
                bus.bean     = 1'($urandom());
            end else if (ins) begin
                bus.video_on = 1'b1; bus.goose = 1'b1; bus.bean = 1'b1;
            end else begin
                bus.video_on = 1'($urandom());
                bus.goose    = 1'($urandom());
                bus.bean     = bus.goose ? 1'b0 : 1'($urandom());
            end
            step();
            if (pt) begin
                if (idx == FP - 1) begin sx = 0; sy = 0; done = 1; end
                else if (sx == H - 1) begin sx = 0; sy++; end
                else sx++;
            end
        end
    endtask

    // Optionally lands the reset on an overlapping frame-tick pixel to show reset wins.
    task automatic do_reset(input int cycles, input bit on_tick);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (on_tick) begin
                sx = H - 1; sy = V - 1;
                bus.x = 10'(sx); bus.y = 10'(sy);
                bus.pixel_tick = 1'b1; bus.video_on = 1'b1; bus.goose = 1'b1; bus.bean = 1'b1;
            end
            step();
        end
        reset = 1'b0;
        sx = 0; sy = 0;
    endtask

    // Monitor: a result is due after every reset cycle and every frame-tick cycle.
    logic ev_q = 1'b0;
    exp_t cur;
    bit   armed = 0;

    always @(posedge clk)
        ev_q <= reset || (bus.pixel_tick && bus.x == 10'(H - 1) && bus.y == 10'(V - 1));

    always @(negedge clk) begin
        if (ev_q) begin
            chk("exp_available", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cur   = exp_q.pop_front();
                armed = 1;
                chk("hit_pulse_frame", int'(bus.hit_pulse), int'(cur.hit));
                chk("lives_left_frame", int'(bus.lives_left), cur.lives);
                chk("check_hit_frame", int'(bus.check_hit), int'(cur.chk));
                chk("game_over_frame", int'(bus.game_over), int'(cur.over));
                chk("flash_frame", int'(bus.flash), int'(cur.flash));
            end
        end else if (armed) begin
            chk("hit_pulse_idle", int'(bus.hit_pulse), 0);
            chk("lives_left_idle", int'(bus.lives_left), cur.lives);
            chk("check_hit_idle", int'(bus.check_hit), int'(cur.chk));
            chk("game_over_idle", int'(bus.game_over), int'(cur.over));
            chk("flash_idle", int'(bus.flash), int'(cur.flash));
        end
    end

    initial begin
        bus.pixel_tick = 1'b0; bus.x = '0; bus.y = '0;
        bus.video_on = 1'b0; bus.goose = 1'b0; bus.bean = 1'b0;
        do_reset(3, 1'b0);

        // Quiet frames, then a 4-pixel hit and the full freeze with busy frames inside it.
        for (int f = 0; f < 3; f++) drive_frame(2, 0, 75);
        drive_frame(2, 4, 75);
        for (int f = 0; f < HS; f++) drive_frame(3, 0, 75);
        // Two sub-threshold frames must not accumulate.
        drive_frame(1, 3, 75);
        drive_frame(2, 3, 75);
        // Fourth overlap on the frame-tick pixel itself.
        drive_frame(1, 4, 60);
        // Reset partway through the freeze, colliding with a frame tick.
        for (int f = 0; f < 10; f++) drive_frame(3, 0, 80);
        do_reset(1, 1'b1);
        // Permanent overlap: three hits spaced by the freeze, then game over.
        for (int f = 0; f < 70; f++) drive_frame(1, FP, 100);
        do_reset(2, 1'b0);
        for (int f = 0; f < 60; f++)
            drive_frame(int'($urandom_range(1, 3)), int'($urandom_range(0, 8)),
                        int'($urandom_range(50, 100)));

        bus.pixel_tick = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
